// File: rtl/sha256_round_ctrl.sv
// rtl/sha256_round_ctrl.sv - SHA-256 round and final-update sequencer over a shared 4-operand adder
module sha256_round_ctrl #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] hash_in,
  input  logic [31:0]  w_in,
  input  logic         w_valid,
  output logic         w_ready,
  output logic [31:0]  add_a,
  output logic [31:0]  add_b,
  output logic [31:0]  add_c,
  output logic [31:0]  add_d,
  output logic         add_cin,
  input  logic [31:0]  add_sum,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out
);

  typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P3, S_FIN, S_DONE} state_e;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] v_q [8];   // working variables a..h
  logic [31:0] v_d [8];
  logic [31:0] h_q [8];   // chaining words H0..H7
  logic [31:0] h_d [8];
  logic [31:0] s1_q, s1_d;
  logic [31:0] enew_q, enew_d;
  logic [31:0] wreg_q, wreg_d;
  logic [5:0]  round_q, round_d;
  logic [2:0]  idx_q, idx_d;

  assign busy     = (state_q != S_IDLE);
  assign hash_out = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};

  // Adder operand mux and handshake outputs; kept apart from next-state so add_sum never loops back here
  always_comb begin
    w_ready = 1'b0;
    done    = 1'b0;
    add_a   = '0;
    add_b   = '0;
    add_c   = '0;
    add_d   = '0;
    add_cin = 1'b0;
    case (state_q)
      S_P1: begin
        add_a = v_q[7];
        add_b = bsig1(v_q[4]);
        add_c = ch(v_q[4], v_q[5], v_q[6]);
        add_d = K_TAB[round_q];
      end
      S_P2: begin
        w_ready = 1'b1;
        if (w_valid) begin
          add_a = v_q[3];
          add_b = s1_q;
          add_c = w_in;
        end
      end
      S_P3: begin
        add_a = s1_q;
        add_b = wreg_q;
        add_c = bsig0(v_q[0]);
        add_d = maj(v_q[0], v_q[1], v_q[2]);
      end
      S_FIN: begin
        add_a = h_q[idx_q];
        add_b = v_q[idx_q];
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Next-state and register updates; S1 holds h+S1+Ch+K so that E_new = d+T1 and a = T1+T2
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    h_d     = h_q;
    s1_d    = s1_q;
    enew_d  = enew_q;
    wreg_d  = wreg_q;
    round_d = round_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < 8; i++) begin
            h_d[i] = hash_in[255 - 32*i -: 32];
            v_d[i] = hash_in[255 - 32*i -: 32];
          end
          round_d = '0;
          state_d = S_P1;
        end
      end
      S_P1: begin
        s1_d    = add_sum;
        state_d = S_P2;
      end
      S_P2: begin
        if (w_valid) begin
          enew_d  = add_sum;
          wreg_d  = w_in;
          state_d = S_P3;
        end
      end
      S_P3: begin
        v_d[7] = v_q[6];
        v_d[6] = v_q[5];
        v_d[5] = v_q[4];
        v_d[4] = enew_q;
        v_d[3] = v_q[2];
        v_d[2] = v_q[1];
        v_d[1] = v_q[0];
        v_d[0] = add_sum;
        if (round_q == 6'(ROUNDS - 1)) begin
          idx_d   = '0;
          state_d = S_FIN;
        end else begin
          round_d = round_q + 6'd1;
          state_d = S_P1;
        end
      end
      S_FIN: begin
        h_d[idx_q] = add_sum;
        idx_d      = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 8; i++) begin
        v_q[i] <= '0;
        h_q[i] <= '0;
      end
      s1_q    <= '0;
      enew_q  <= '0;
      wreg_q  <= '0;
      round_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      h_q     <= h_d;
      s1_q    <= s1_d;
      enew_q  <= enew_d;
      wreg_q  <= wreg_d;
      round_q <= round_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
- Sequences the 64 SHA-256 compression rounds and the final hash update over one shared external 4-operand modulo-2^32 adder (the compressor datapath).
- Holds working variables a..h and hash words H0..H7, and contains the K constant table.
- Consumes one message-schedule word W[t] per round through a valid/ready handshake.
- Sits between the message scheduler and the digest output of the SHA-256 core.

Parameters:
ROUNDS, 64, number of compression rounds per block; 64 for SHA-256, smaller values only for debug benches.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin one block; sampled only in IDLE
hash_in  input  256  chaining value {H0..H7}, H0 in [255:224]; latched on accepted start
w_in  input  32  message schedule word W[t]
w_valid  input  1  w_in valid
w_ready  output  1  controller accepts W this cycle
add_a  output  32  adder operand A
add_b  output  32  adder operand B
add_c  output  32  adder operand C
add_d  output  32  adder operand D
add_cin  output  1  adder carry-in, tied 0
add_sum  input  32  adder result, combinational from the operands in the same cycle; adder carry-out is not used
busy  output  1  high from the cycle after an accepted start until DONE is left
done  output  1  one-cycle pulse, digest valid
hash_out  output  256  {H0..H7}, same packing as hash_in

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; a..h, H0..H7, S1, E_new, Wreg, round and idx clear to 0.
  - hash_out=0, done=0, busy=0, w_ready=0.
  - add_a..add_d=0, add_cin=0.
- Operands are 0 in every state that does not use the adder. All sums are mod 2^32.
- IDLE: on start=1, load H0..H7 and a..h from hash_in, set round=0, go to P1.
- P1: drive add_a=h, add_b=Σ1(e), add_c=Ch(e,f,g), add_d=K[round]. Register S1<=add_sum. Go to P2.
- P2: w_ready=1. Hold while w_valid=0; operands stay 0. On w_valid=1:
  - drive add_a=d, add_b=S1, add_c=w_in, add_d=0;
  - register E_new<=add_sum and Wreg<=w_in;
  - go to P3.
- P3: drive add_a=S1, add_b=Wreg, add_c=Σ0(a), add_d=Maj(a,b,c). Then update:
  - h<=g, g<=f, f<=e, e<=E_new, d<=c, c<=b, b<=a, a<=add_sum;
  - if round==ROUNDS-1, go to FIN with idx=0;
  - otherwise round<=round+1 and go to P1.
- FIN: on each cycle idx=0..7, drive add_a=H[idx], add_b=var[idx] (var order a..h), add_c=add_d=0, and register H[idx]<=add_sum. After idx=7, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. hash_out reflects the H registers continuously and holds until the next accepted start.
- Function definitions:
  - Σ0 = ROTR2^ROTR13^ROTR22;
  - Σ1 = ROTR6^ROTR11^ROTR25;
  - Ch = (e&f)^(~e&g);
  - Maj = (a&b)^(a&c)^(b&c).
- Latency with w_valid held high: the start sample cycle is 0, rounds occupy cycles 1..3*ROUNDS, FIN takes 8 cycles, and done is at cycle 3*ROUNDS+9 (201 for 64 rounds).
- Each W stall cycle adds exactly one cycle.
- start outside IDLE is ignored, and hash_in is not re-latched. start in DONE is ignored.
- w_valid outside P2 is ignored and no word is consumed. Exactly ROUNDS words are consumed per block.
- Reset asserted mid-block aborts immediately. No done pulse is produced, and state returns to the reset values above.

Test Plan:
- "abc" single block: IV=6a09e667..5be0cd19, W stream from the padded "abc" schedule, w_valid held 1 -> done at cycle 201, hash_out=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Round-0 P1 operand check after IV load -> add_a=5be0cd19, add_d=428a2f98. In the first P2, add_a=a54ff53a. add_cin=0 throughout.
- W stalls: same "abc" vector with w_valid low for 3 cycles in rounds 0, 31 and 63 -> identical digest, done at cycle 210, w_ready high only in P2.
- Two-block chaining: "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", with block 2 started from hash_out of block 1 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- start pulsed in rounds 10 and 40 and in DONE -> no restart, digest unchanged, single done pulse.
- rst_n low in round 20 -> all outputs 0 asynchronously, no done. A fresh "abc" run afterwards gives the correct digest.
